mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (LD > DM > IF) onto one synchronous memory port, with LD lock and IF anti-starvation.
// Grant and memory controls are combinational; responses return exactly one cycle after the grant.
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MAX_RUN = 3
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  input  logic            ld_lock,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            locked,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          locked_q, locked_d;
  logic [2:0]    rvalid_q;
  logic [2:0]    grant;
  logic          starved;
  logic          unused_we2;

  // IF is read-only, so its write enable never reaches the memory.
  assign unused_we2 = we[2];
  assign starved    = req[2] && (starve_q == CW'(MAX_RUN));

  always_comb begin
    grant = 3'b000;
    if (locked_q)     grant = {2'b00, req[0]};
    else if (req[0])  grant = 3'b001;
    else if (starved) grant = 3'b100;
    else if (req[1])  grant = 3'b010;
    else if (req[2])  grant = 3'b100;
  end

  always_comb begin
    mem_addr  = addr[2*AW +: AW];
    mem_wdata = wdata[2*DW +: DW];
    if (grant[0]) begin
      mem_addr  = addr[0 +: AW];
      mem_wdata = wdata[0 +: DW];
    end else if (grant[1]) begin
      mem_addr  = addr[AW +: AW];
      mem_wdata = wdata[DW +: DW];
    end
  end

  assign gnt    = grant;
  assign mem_en = (|grant) & ~rst;
  assign mem_we = (grant[0] & we[0]) | (grant[1] & we[1]);

  always_comb begin
    starve_d = starve_q;
    locked_d = locked_q;
    if (grant[0]) locked_d = ld_lock;
    // Only DM grants count as denials; a loss to LD or a lock does not.
    if (!locked_q) begin
      if (grant[2] || !req[2])
        starve_d = '0;
      else if (grant[1] && (starve_q != CW'(MAX_RUN)))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      locked_q <= 1'b0;
      rvalid_q <= 3'b000;
    end else begin
      starve_q <= starve_d;
      locked_q <= locked_d;
      rvalid_q <= grant;
    end
  end

  assign rvalid = rvalid_q;
  assign locked = locked_q;
  assign rdata  = (|rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and random traffic vs. a reference model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MAX_RUN = 3;

  logic            clk1, rst;
  logic [2:0]      req, we, gnt, rvalid;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic            ld_lock, locked, mem_en, mem_we;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_RUN(MAX_RUN)) dut (
    .clk1(clk1), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ld_lock(ld_lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Synchronous memory attached to the port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_rd;
  assign mem_rdata = mem_rd;
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rd <= mem[mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: who may use the port this cycle, plus what the memory should hold.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_locked;
  int            m_cnt;
  logic [2:0]    m_prev;
  bit            m_wr;
  logic [DW-1:0] m_rd;

  function automatic void m_reset();
    m_locked = 0; m_cnt = 0; m_prev = 3'b000; m_wr = 0; m_rd = '0;
  endfunction

  function automatic logic [2:0] model_gnt();
    if (m_locked) return req[0] ? 3'b001 : 3'b000;
    if (req[0]) return 3'b001;
    if (req[2] && m_cnt >= MAX_RUN) return 3'b100;
    if (req[1]) return 3'b010;
    if (req[2]) return 3'b100;
    return 3'b000;
  endfunction

  task automatic tick(input logic [2:0] tg, input logic tl, input bit use_tbl);
    logic [2:0] eg;
    int g;
    bit old_lk, wr;
    logic [AW-1:0] a;
    @(negedge clk1);
    eg = model_gnt();
    g = eg[0] ? 0 : (eg[1] ? 1 : 2);
    wr = (eg != 3'b000) && (g != 2) && we[g];
    a = addr[g*AW +: AW];
    chk("gnt", 64'(gnt), 64'(eg));
    chk("mem_en", 64'(mem_en), 64'(eg != 3'b000));
    chk("mem_we", 64'(mem_we), 64'(wr));
    if (eg != 3'b000) begin
      chk("mem_addr", 64'(mem_addr), 64'(a));
      if (wr) chk("mem_wdata", 64'(mem_wdata), 64'(wdata[g*DW +: DW]));
    end
    chk("rvalid", 64'(rvalid), 64'(m_prev));
    if (m_prev == 3'b000) chk("rdata_idle", 64'(rdata), 64'(0));
    else if (!m_wr)       chk("rdata", 64'(rdata), 64'(m_rd));
    chk("locked", 64'(locked), 64'(m_locked));
    if (use_tbl) begin
      chk("tbl_gnt", 64'(gnt), 64'(tg));
      chk("tbl_locked", 64'(locked), 64'(tl));
    end
    old_lk = m_locked;
    if (eg != 3'b000) begin
      if (wr) ref_mem[a] = wdata[g*DW +: DW];
      else    m_rd = ref_mem[a];
      m_wr = wr;
    end
    m_prev = eg;
    if (eg[0]) m_locked = ld_lock;
    if (!old_lk) begin
      if (eg[2] || !req[2]) m_cnt = 0;
      else if (eg[1] && m_cnt < MAX_RUN) m_cnt++;
    end
    @(posedge clk1); #1;
  endtask

  task automatic drv(input logic [2:0] r, input logic [2:0] w, input logic l);
    req = r; we = w; ld_lock = l;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       ld;
    logic [2:0] gnt;
    logic       lk;
  } vec_t;
  vec_t tbl[$];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rd = '0;
    rst = 1'b1; req = 3'b000; we = 3'b000; ld_lock = 1'b0; addr = '0; wdata = '0;
    m_reset();

    // lock burst with DM waiting, DM/IF rotation, three-way collision, lock with IF pending, IF drop
    tbl.push_back('{3'b011, 1'b1, 3'b001, 1'b0});
    tbl.push_back('{3'b011, 1'b1, 3'b001, 1'b1});
    tbl.push_back('{3'b011, 1'b1, 3'b001, 1'b1});
    tbl.push_back('{3'b011, 1'b0, 3'b001, 1'b1});
    tbl.push_back('{3'b010, 1'b0, 3'b010, 1'b0});
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
      tbl.push_back('{3'b110, 1'b0, 3'b100, 1'b0});
    end
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b001, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b100, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b111, 1'b1, 3'b001, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b000, 1'b1});
    tbl.push_back('{3'b110, 1'b0, 3'b000, 1'b1});
    tbl.push_back('{3'b111, 1'b0, 3'b001, 1'b1});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b100, 1'b0});
    tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b010, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b110, 1'b0, 3'b010, 1'b0});
    tbl.push_back('{3'b000, 1'b0, 3'b000, 1'b0});

    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    @(posedge clk1); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].req, 3'b000, tbl[i].ld);
      tick(tbl[i].gnt, tbl[i].lk, 1);
    end

    // LD write then IF read of the same word
    addr = '0; wdata = '0;
    wdata[0 +: DW] = 32'h28010003;
    drv(3'b001, 3'b001, 1'b0); tick(3'b001, 1'b0, 1);
    drv(3'b100, 3'b000, 1'b0); tick(3'b100, 1'b0, 1);
    chk("s1_rvalid", 64'(rvalid), 64'(3'b100));
    chk("s1_rdata", 64'(rdata), 64'(32'h28010003));

    // DM write then read back-to-back
    addr[AW +: AW] = 5; wdata[DW +: DW] = 32'h00632000;
    drv(3'b010, 3'b010, 1'b0); tick(3'b010, 1'b0, 1);
    chk("s6_wack", 64'(rvalid), 64'(3'b010));
    drv(3'b010, 3'b000, 1'b0); tick(3'b010, 1'b0, 1);
    chk("s6_rvalid", 64'(rvalid), 64'(3'b010));
    chk("s6_rdata", 64'(rdata), 64'(32'h00632000));

    // reset with a lock held, a full starvation count and a response in flight
    addr = '0;
    for (int j = 0; j < 3; j++) begin drv(3'b110, 3'b000, 1'b0); tick(3'b010, 1'b0, 1); end
    drv(3'b101, 3'b000, 1'b1); tick(3'b001, 1'b0, 1);
    drv(3'b000, 3'b000, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst1_rvalid", 64'(rvalid), 64'(0));
    chk("rst1_locked", 64'(locked), 64'(0));
    #1 rst = 1'b0;
    m_reset();
    drv(3'b110, 3'b000, 1'b0); tick(3'b010, 1'b0, 1);

    // IF read interrupted by a 2 ns reset pulse
    drv(3'b100, 3'b000, 1'b0); tick(3'b100, 1'b0, 1);
    drv(3'b000, 3'b000, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst2_rvalid", 64'(rvalid), 64'(0));
    chk("rst2_rdata", 64'(rdata), 64'(0));
    #1 rst = 1'b0;
    m_reset();
    tick(3'b000, 1'b0, 1);

    // grant stays visible but the port is disabled while reset is held
    drv(3'b010, 3'b010, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstg_gnt", 64'(gnt), 64'(3'b010));
    chk("rstg_mem_en", 64'(mem_en), 64'(0));
    drv(3'b000, 3'b000, 1'b0);
    #1 rst = 1'b0;
    m_reset();
    tick(3'b000, 1'b0, 1);

    for (int n = 0; n < 3000; n++) begin
      req = 3'($urandom_range(0, 7));
      we = 3'($urandom_range(0, 7));
      ld_lock = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 3; r++) begin
        addr[r*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[r*DW +: DW] = $urandom;
      end
      tick(3'b000, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
